// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the configurable UART receiver/transmitter.
package uart_pkg;
  localparam int DBIT_MIN = 5;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} par_mode_t;
  function automatic par_mode_t par_decode(input logic [1:0] c);
    return c == 2'b01 ? PAR_EVEN : c == 2'b10 ? PAR_ODD : PAR_NONE;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversampling tick, one pulse every dvsr+1 clocks; divisor reloads at each wrap.
module uart_baud_gen #(
  parameter int DVSR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick
);
  logic [DVSR_W-1:0] cnt_q, cnt_d, lim_q;
  assign tick  = cnt_q == lim_q;
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (tick) lim_q <= dvsr;
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: run-time configurable UART receiver with valid/ready delivery and status flags.
// Define UART_RX_PARITY_EN to include the parity state and check.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT_MAX = 8,
  parameter int OVS      = 16,
  parameter int DVSR_W   = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DVSR_W-1:0]   dvsr,
  input  logic [3:0]          cfg_dbits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop2,
  input  logic                rx,
  output logic [DBIT_MAX-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det,
  output logic                overrun
);
  localparam int SW = $clog2(OVS);
  localparam logic [SW-1:0] S_MID = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OVS - 1);
  localparam logic [3:0] DMIN = 4'(DBIT_MIN);
  localparam logic [3:0] DMAX = 4'(DBIT_MAX);

  logic tick, rx_s, mid, samp, deliver, load;
  logic [1:0] sync_q;
  rx_state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d, s_nx;
  logic [3:0] n_q, n_d, dbits_q, dbits_d, dbits_c;
  logic [DBIT_MAX-1:0] sh_q, sh_d;
  par_mode_t par_q, par_d, par_c;
  logic stop2_q, stop2_d, perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;

  uart_baud_gen #(.DVSR_W(DVSR_W)) u_baud (.clk(clk), .reset_n(reset_n), .dvsr(dvsr), .tick(tick));

  assign rx_s    = sync_q[1];
  assign mid     = tick && s_q == S_MID;
  assign samp    = tick && s_q == S_END;
  assign s_nx    = samp ? '0 : s_q + 1'b1;
  assign dbits_c = cfg_dbits < DMIN ? DMIN : cfg_dbits > DMAX ? DMAX : cfg_dbits;
`ifdef UART_RX_PARITY_EN
  assign par_c = par_decode(cfg_parity);
`else
  assign par_c = PAR_NONE;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    dbits_d = dbits_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    zero_d  = zero_q;
    deliver = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        s_d     = '0;
      end
      START: if (mid) begin
        state_d = rx_s ? IDLE : DATA;
        s_d     = '0;
        n_d     = '0;
        sh_d    = '0;
        dbits_d = dbits_c;
        par_d   = par_c;
        stop2_d = cfg_stop2;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        zero_d  = 1'b1;
      end else if (tick) s_d = s_q + 1'b1;
      DATA: begin
        if (tick) s_d = s_nx;
        if (samp) begin
          sh_d   = {rx_s, sh_q[DBIT_MAX-1:1]};
          n_d    = n_q + 1'b1;
          zero_d = zero_q & ~rx_s;
          if (n_q == dbits_q - 4'd1) begin
            n_d     = '0;
            state_d = par_q == PAR_NONE ? STOP : PARITY;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) s_d = s_nx;
        if (samp) begin
          perr_d  = (^sh_q ^ rx_s) != (par_q == PAR_ODD);
          zero_d  = zero_q & ~rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) s_d = s_nx;
        if (samp) begin
          ferr_d = ferr_q | ~rx_s;
          if (n_q == '0) zero_d = zero_q & ~rx_s;
          if (stop2_q && n_q == '0) n_d = 4'd1;
          else begin
            deliver = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A frame completing while the previous one is still held (and not being taken) is dropped.
  assign load = deliver && (!rx_valid || rx_ready);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      sh_q       <= '0;
      dbits_q    <= DMAX;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      sh_q      <= sh_d;
      dbits_q   <= dbits_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      zero_q    <= zero_d;
      break_det <= deliver && zero_d;
      overrun   <= deliver && !load;
      if (load) begin
        rx_data    <= sh_q >> (DMAX - dbits_q);
        parity_err <= perr_q;
        frame_err  <= ferr_d;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench; expected frames queued at send time, popped on each handshake.
module tb_uart_rx_cfg;
  localparam int BIT = 48;
  logic clk = 1'b0, reset_n = 1'b0, rx = 1'b1, rx_ready = 1'b1, cfg_stop2 = 1'b0;
  logic [10:0] dvsr = 11'd2;
  logic [3:0] cfg_dbits = 4'd8;
  logic [1:0] cfg_parity = 2'b00;
  logic [7:0] rx_data;
  logic rx_valid, parity_err, frame_err, break_det, overrun;
  int passed = 0, total = 0, brk_cnt = 0, ovr_cnt = 0, vcyc = 0;
  logic [9:0] exp_q[$];
  logic [9:0] e;

  uart_rx_cfg dut (
    .clk(clk), .reset_n(reset_n), .dvsr(dvsr), .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (break_det) brk_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid) vcyc++;
      if (rx_valid && rx_ready) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL unexpected_frame: got data=%h pe=%b fe=%b, none expected", rx_data, parity_err, frame_err);
        else begin
          e = exp_q.pop_front();
          if ({rx_data, parity_err, frame_err} !== e)
            $display("FAIL frame: got data=%h pe=%b fe=%b, want data=%h pe=%b fe=%b", rx_data, parity_err, frame_err, e[9:2], e[1], e[0]);
          else passed++;
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
    exp_q.push_back({d, pe, fe});
  endtask

  task automatic send(input logic [7:0] d, input int nb, input bit par_en, input logic pb, input int ns, input logic [1:0] st);
    rx = 1'b0;
    hold(BIT);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      hold(BIT);
    end
    if (par_en) begin
      rx = pb;
      hold(BIT);
    end
    for (int i = 0; i < ns; i++) begin
      rx = st[i];
      if (i == ns - 1 && !st[i]) begin
        hold(BIT * 3 / 4);
        rx = 1'b1;
        hold(BIT / 4);
      end else hold(BIT);
    end
    rx = 1'b1;
    hold(BIT * 2);
  endtask

  task automatic test_reset;
    hold(3);
    total++;
    if ({rx_data, rx_valid, parity_err, frame_err, break_det, overrun} !== 13'd0)
      $display("FAIL reset_outputs: got %h, want 0", {rx_data, rx_valid, parity_err, frame_err, break_det, overrun});
    else passed++;
    reset_n = 1'b1;
    hold(10);
    total++;
    if (rx_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b, want 0", rx_valid);
    else passed++;
  endtask

  task automatic test_8n1;
    int v0, b0, o0;
    v0 = vcyc; b0 = brk_cnt; o0 = ovr_cnt;
    expect_frame(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 8, 0, 1'b0, 1, 2'b11);
    total++;
    if (vcyc - v0 !== 1) $display("FAIL 8n1_valid_cycles: got %0d, want 1", vcyc - v0);
    else passed++;
    total++;
    if (brk_cnt - b0 + ovr_cnt - o0 !== 0) $display("FAIL 8n1_pulses: got %0d, want 0", brk_cnt - b0 + ovr_cnt - o0);
    else passed++;
  endtask

  task automatic test_parity;
    cfg_dbits = 4'd7; cfg_parity = 2'b01;
`ifdef UART_RX_PARITY_EN
    expect_frame(8'h35, 1'b0, 1'b0);
    send(8'h35, 7, 1, 1'b0, 1, 2'b11);
    expect_frame(8'h35, 1'b1, 1'b0);
    send(8'h35, 7, 1, 1'b1, 1, 2'b11);
`else
    expect_frame(8'h35, 1'b0, 1'b0);
    send(8'h35, 7, 0, 1'b0, 1, 2'b11);
    expect_frame(8'h4A, 1'b0, 1'b0);
    send(8'h4A, 7, 0, 1'b0, 1, 2'b11);
`endif
    total++;
    if (exp_q.size() !== 0) $display("FAIL parity_drain: got %0d pending, want 0", exp_q.size());
    else passed++;
    cfg_parity = 2'b00;
  endtask

  task automatic test_stop2_break;
    int b0;
    cfg_dbits = 4'd5; cfg_stop2 = 1'b1;
    b0 = brk_cnt;
    expect_frame(8'h1B, 1'b0, 1'b1);
    send(8'h1B, 5, 0, 1'b0, 2, 2'b01);
    total++;
    if (brk_cnt !== b0) $display("FAIL stop2_no_break: got %0d, want %0d", brk_cnt, b0);
    else passed++;
    expect_frame(8'h00, 1'b0, 1'b1);
    send(8'h00, 5, 0, 1'b0, 2, 2'b10);
    total++;
    if (brk_cnt - b0 !== 1) $display("FAIL break_pulse: got %0d, want 1", brk_cnt - b0);
    else passed++;
    cfg_dbits = 4'd8; cfg_stop2 = 1'b0;
  endtask

  task automatic test_overrun;
    int o0;
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    expect_frame(8'h11, 1'b0, 1'b0);
    send(8'h11, 8, 0, 1'b0, 1, 2'b11);
    send(8'h22, 8, 0, 1'b0, 1, 2'b11);
    total++;
    if (ovr_cnt - o0 !== 1) $display("FAIL overrun_pulse: got %0d, want 1", ovr_cnt - o0);
    else passed++;
    total++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h11}) $display("FAIL overrun_hold: got valid=%b data=%h, want 1 11", rx_valid, rx_data);
    else passed++;
    rx_ready = 1'b1;
    hold(1);
    total++;
    if (rx_valid !== 1'b0) $display("FAIL ready_drop: got %b, want 0", rx_valid);
    else passed++;
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vcyc;
    rx = 1'b0;
    hold(12);
    rx = 1'b1;
    hold(BIT * 3);
    total++;
    if (vcyc !== v0) $display("FAIL glitch_valid: got %0d cycles, want 0", vcyc - v0);
    else passed++;
    expect_frame(8'h5A, 1'b0, 1'b0);
    send(8'h5A, 8, 0, 1'b0, 1, 2'b11);
  endtask

  task automatic test_reset_mid;
    rx_ready = 1'b0;
    send(8'h77, 8, 0, 1'b0, 1, 2'b11);
    total++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h77}) $display("FAIL held_before_reset: got valid=%b data=%h, want 1 77", rx_valid, rx_data);
    else passed++;
    rx = 1'b0;
    hold(BIT * 3);
    reset_n = 1'b0;
    rx = 1'b1;
    hold(3);
    reset_n = 1'b1;
    total++;
    if ({rx_data, rx_valid, parity_err, frame_err, break_det, overrun} !== 13'd0)
      $display("FAIL reset_mid_outputs: got %h, want 0", {rx_data, rx_valid, parity_err, frame_err, break_det, overrun});
    else passed++;
    rx_ready = 1'b1;
    hold(BIT * 2);
    expect_frame(8'h3C, 1'b0, 1'b0);
    send(8'h3C, 8, 0, 1'b0, 1, 2'b11);
    total++;
    if (exp_q.size() !== 0) $display("FAIL final_drain: got %0d pending, want 0", exp_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2_break();
    test_overrun();
    test_glitch();
    test_reset_mid();
    hold(5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised UART receiver, successor to the fixed-format receiver inside the uart block.
- Data bits (5..DBIT_MAX), parity mode and stop-bit count are selectable at run time.
- Integrated baud tick generator; delivers frames over a valid/ready handshake with per-frame status flags.
- Sits between the rx pad (or tx loopback) and the rx FIFO/consumer.

Parameters:
DBIT_MAX, 8, widest data field supported; also the width of rx_data
OVS, 16, oversampling ticks per bit; must be even and ≥4
DVSR_W, 11, width of the baud divisor

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
dvsr  in  DVSR_W  baud divisor; one tick every dvsr+1 clocks
cfg_dbits  in  4  data bits; values <5 act as 5, values >DBIT_MAX act as DBIT_MAX
cfg_parity  in  2  00/11 none, 01 even, 10 odd
cfg_stop2  in  1  1 = two stop bits checked
rx  in  1  serial input, idle high, asynchronous
rx_data  out  DBIT_MAX  received data, right-justified, upper bits zero
rx_valid  out  1  frame available
rx_ready  in  1  consumer accepts when rx_valid&&rx_ready
parity_err  out  1  status of held frame, qualified by rx_valid
frame_err  out  1  any checked stop bit sampled 0, qualified by rx_valid
break_det  out  1  1-cycle pulse: data=0, parity bit (if any)=0, first stop=0
overrun  out  1  1-cycle pulse: completed frame dropped

Behaviour:
- Reset: all outputs 0, FSM IDLE, tick counter 0. The 2-FF rx synchroniser resets to 1.
- Tick: counter counts 0..dvsr and pulses tick on the terminal count. dvsr=0 gives a tick every clock. A dvsr change takes effect at the next wrap.
- FSM states: IDLE, START, DATA, PARITY, STOP. Let s be the tick counter and n the bit counter.
- IDLE → START when synchronised rx_s==0; s cleared.
- START: on tick with s==OVS/2-1:
  - rx_s==0 → DATA; s,n cleared; cfg_dbits/cfg_parity/cfg_stop2 latched.
  - Otherwise → IDLE (glitch rejected, nothing reported).
- Config changes mid-frame have no effect until the next START→DATA.
- DATA: on tick with s==OVS-1, shift rx_s into the MSB of the shift register and increment n. After the last data bit, go to PARITY if parity is enabled, else STOP.
- PARITY: sample at s==OVS-1. The error is set if XOR(data, bit) ≠ 0 for even parity, or ≠ 1 for odd parity.
- STOP: sample each stop bit at s==OVS-1. A 0 on any sampled stop bit sets frame_err. After the last stop sample: deliver, then → IDLE in the same cycle.
- Latency: delivery occurs mid-way through the last stop bit, so a back-to-back start bit is not missed.
- Delivery:
  - rx_data = shift register >> (DBIT_MAX - dbits); parity_err and frame_err are loaded with it; rx_valid=1.
  - If rx_valid is already high and not accepted in that same cycle: pulse overrun. The held rx_data and flags are unchanged and the new frame is discarded.
  - If an acceptance and a delivery occur in the same cycle, the new frame loads and no overrun occurs.
- Handshake: rx_valid stays high until rx_valid&&rx_ready. It clears on the following edge unless a new frame loads in that same cycle.
- break_det pulses at delivery (or at the drop, on overrun) independently of rx_valid. A break frame is still delivered with frame_err=1.
- Reset mid-frame: the frame is aborted with no output. The receiver resynchronises on the next falling edge after rx returns high.

Optional Feature:
- UART_RX_PARITY_EN defined: PARITY state and checks are present.
- Undefined: PARITY state removed, cfg_parity ignored (treated as none), parity_err tied 0; frame timing is as for parity none.

Decomposition:
- uart_pkg:
  - rx_state_t enum.
  - par_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD) with a decode function from the 2-bit cfg_parity.
  - DBIT_MIN=5 constant.
- Sub-module uart_baud_gen (clk, reset_n, dvsr → tick), reusable by the matching transmitter.

Test Plan:
- 8N1: dvsr=2 (48 clk/bit), rx_ready=1, send 0xA5 → rx_valid 1 cycle, rx_data=0xA5, all flags 0.
- 7E1 (cfg_dbits=7, cfg_parity=01), send 0x35 with parity bit 0 → rx_data=0x35, parity_err=0. Resend with parity bit 1 → parity_err=1.
- 5 data bits, two stop bits, second stop driven 0, data 0x1B → rx_data=0x1B, frame_err=1. All-zero frame with stop=0 → break_det pulse, frame_err=1.
- rx_ready=0, send 0x11 then 0x22 → overrun pulse at the second delivery, rx_data stays 0x11. Assert rx_ready → rx_valid drops the next cycle.
- 12-clock low glitch on rx (below half a bit) → FSM returns to IDLE, no rx_valid.
- reset_n low for 3 clocks mid-data of a frame → all outputs 0. The next 8N1 frame 0x3C is received correctly.
